// File: rtl/lock_ctrl_fsm.sv
// Keypad lock control FSM: captures an 8-digit password, checks entries digit by digit,
// and drives the state code and entered-digit history for the display stage.
module lock_ctrl_fsm #(
    parameter int OPEN_TIMEOUT = 1000,
    parameter int CNT_W        = 10
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic        digit_strb,
    input  logic [3:0]  digit,
    input  logic        enter_strb,
    output logic [3:0]  state,
    output logic [31:0] seq
);

    typedef enum logic [3:0] {
        LS0   = 4'h0,
        LS1   = 4'h1,
        LS2   = 4'h2,
        LS3   = 4'h3,
        LS4   = 4'h4,
        LS5   = 4'h5,
        LS6   = 4'h6,
        LS7   = 4'h7,
        OPEN  = 4'h8,
        ALARM = 4'h9,
        INIT  = 4'hA
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(OPEN_TIMEOUT - 1);

    state_t           state_q, state_n;
    logic [31:0]      seq_q, seq_n;
    logic [31:0]      pwd_q, pwd_n;
    logic [3:0]       dcnt_q, dcnt_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic [31:0] seq_shift;
    logic [3:0]  pwd_nib;

    always_comb begin
        seq_shift = {seq_q[27:0], digit};
        // nibble k of the password sits at bit (7-k)*4; ~k equals 7-k for 3 bits
        pwd_nib   = pwd_q[{~state_q[2:0], 2'b00} +: 4];
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q <= INIT;
            seq_q   <= '0;
            pwd_q   <= '0;
            dcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            seq_q   <= seq_n;
            pwd_q   <= pwd_n;
            dcnt_q  <= dcnt_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        seq_n   = seq_q;
        pwd_n   = pwd_q;
        dcnt_n  = dcnt_q;
        cnt_n   = cnt_q;

        case (state_q)
            INIT: begin
                if (enter_strb) begin
                    if (dcnt_q == 4'd8) begin
                        pwd_n   = seq_q;
                        seq_n   = '0;
                        dcnt_n  = '0;
                        state_n = LS0;
                    end
                end else if (digit_strb) begin
                    seq_n  = seq_shift;
                    dcnt_n = (dcnt_q == 4'd8) ? 4'd8 : dcnt_q + 4'd1;
                end
            end

            LS0, LS1, LS2, LS3, LS4, LS5, LS6, LS7: begin
                if (enter_strb) begin
                    seq_n   = '0;
                    state_n = LS0;
                end else if (digit_strb) begin
                    seq_n = seq_shift;
                    if (digit != pwd_nib) begin
                        state_n = ALARM;
                    end else if (state_q == LS7) begin
                        state_n = OPEN;
                        cnt_n   = '0;
                    end else begin
                        state_n = state_t'(state_q + 4'd1);
                    end
                end
            end

            OPEN: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (enter_strb || cnt_q == TO_LAST) begin
                    state_n = LS0;
                    seq_n   = '0;
                    cnt_n   = '0;
                end
            end

            ALARM: begin
                state_n = ALARM;
            end

            default: begin
                state_n = INIT;
                seq_n   = '0;
                dcnt_n  = '0;
                cnt_n   = '0;
            end
        endcase
    end

    assign state = state_q;
    assign seq   = seq_q;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Bench for lock_ctrl_fsm: vector table plus hand-written multi-cycle sequences,
// expectations queued at drive time and checked after each clock edge.
module tb_lock_ctrl_fsm;

    localparam int TO = 1000;

    logic        hz100;
    logic        reset;
    logic        digit_strb;
    logic [3:0]  digit;
    logic        enter_strb;
    logic [3:0]  state;
    logic [31:0] seq;

    lock_ctrl_fsm #(.OPEN_TIMEOUT(TO), .CNT_W(10)) dut (
        .hz100      (hz100),
        .reset      (reset),
        .digit_strb (digit_strb),
        .digit      (digit),
        .enter_strb (enter_strb),
        .state      (state),
        .seq        (seq)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    typedef struct {
        logic        rst;
        logic        ds;
        logic [3:0]  d;
        logic        es;
        logic [3:0]  st;
        logic [31:0] sq;
    } vec_t;

    typedef struct {
        int          id;
        logic [3:0]  st;
        logic [31:0] sq;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          step  = 0;
    logic [31:0] eseq  = '0;

    always @(posedge hz100) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (state !== mon_e.st || seq !== mon_e.sq) begin
                n_err++;
                $display("FAIL step%0d: state=%h seq=%h, expected state=%h seq=%h",
                         mon_e.id, state, seq, mon_e.st, mon_e.sq);
            end
        end
    end

    task automatic drive(input logic r, input logic ds, input logic [3:0] d,
                         input logic es, input logic [3:0] est,
                         input logic [31:0] esq);
        @(negedge hz100);
        reset      = r;
        digit_strb = ds;
        digit      = d;
        enter_strb = es;
        step++;
        exp_q.push_back('{step, est, esq});
    endtask

    task automatic key(input logic [3:0] d, input logic [3:0] est);
        eseq = {eseq[27:0], d};
        drive(1'b0, 1'b1, d, 1'b0, est, eseq);
    endtask

    task automatic idle(input logic [3:0] est);
        drive(1'b0, 1'b0, 4'h0, 1'b0, est, eseq);
    endtask

    task automatic do_reset();
        eseq = '0;
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'hA, 32'h0);
    endtask

    task automatic enter(input logic [3:0] est, input logic clr);
        if (clr) eseq = '0;
        drive(1'b0, 1'b0, 4'h0, 1'b1, est, eseq);
    endtask

    // full correct entry of 12345678 from LS0 ending in OPEN
    task automatic enter_pwd();
        for (int k = 1; k <= 8; k++) key(4'(k), 4'(k));
    endtask

    vec_t tbl[12];

    initial begin
        reset      = 1'b1;
        digit_strb = 1'b0;
        digit      = 4'h0;
        enter_strb = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'hA, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 4'h1, 1'b0, 4'hA, 32'h1};
        tbl[2]  = '{1'b0, 1'b1, 4'h2, 1'b0, 4'hA, 32'h12};
        tbl[3]  = '{1'b0, 1'b1, 4'h3, 1'b0, 4'hA, 32'h123};
        tbl[4]  = '{1'b0, 1'b1, 4'h4, 1'b0, 4'hA, 32'h1234};
        tbl[5]  = '{1'b0, 1'b1, 4'h5, 1'b0, 4'hA, 32'h12345};
        tbl[6]  = '{1'b0, 1'b1, 4'h6, 1'b0, 4'hA, 32'h123456};
        tbl[7]  = '{1'b0, 1'b1, 4'h7, 1'b0, 4'hA, 32'h1234567};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'hA, 32'h1234567};
        tbl[9]  = '{1'b0, 1'b1, 4'h8, 1'b0, 4'hA, 32'h12345678};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0};

        for (int i = 0; i < 12; i++)
            drive(tbl[i].rst, tbl[i].ds, tbl[i].d, tbl[i].es, tbl[i].st, tbl[i].sq);

        // correct entry, then idle timeout: 1000 cycles in OPEN
        eseq = '0;
        enter_pwd();
        for (int i = 1; i < TO; i++) idle(4'h8);
        eseq = '0;
        idle(4'h0);
        idle(4'h0);

        // enter at cycle 5 in OPEN relocks at once
        enter_pwd();
        for (int i = 1; i < 5; i++) idle(4'h8);
        enter(4'h0, 1'b1);
        idle(4'h0);

        // clear partial entry from LS3, then full entry
        key(4'h1, 4'h1);
        key(4'h2, 4'h2);
        key(4'h3, 4'h3);
        enter(4'h0, 1'b1);
        idle(4'h0);
        enter_pwd();
        idle(4'h8);
        do_reset();

        // alarm is sticky; only reset leaves it
        for (int k = 1; k <= 8; k++) key(4'(k), 4'hA);
        enter(4'h0, 1'b1);
        key(4'h1, 4'h1);
        key(4'h2, 4'h2);
        key(4'h9, 4'h9);
        drive(1'b0, 1'b1, 4'h4, 1'b0, 4'h9, 32'h129);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'h9, 32'h129);
        drive(1'b0, 1'b1, 4'h5, 1'b1, 4'h9, 32'h129);
        idle(4'h9);
        do_reset();

        // simultaneous digit+enter with 8 digits: enter wins
        for (int k = 8; k >= 1; k--) key(4'(k), 4'hA);
        drive(1'b0, 1'b1, 4'h9, 1'b1, 4'h0, 32'h0);
        eseq = '0;
        for (int k = 0; k < 8; k++) key(4'(8 - k), 4'(k + 1));
        idle(4'h8);
        do_reset();

        // nine digits: oldest shifted out, password 23456789
        for (int k = 1; k <= 9; k++) key(4'(k), 4'hA);
        enter(4'h0, 1'b1);
        key(4'h2, 4'h1);
        key(4'h3, 4'h2);
        key(4'h1, 4'h9);
        do_reset();

        @(negedge hz100);
        reset = 1'b0;
        @(negedge hz100);
        @(negedge hz100);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: pending=%0d, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
